// File: rtl/axi_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : axi_frame_reader
// Desc     : AXI4 burst read master streaming a stored 32-bit/pixel frame out
//            as a valid/ready pixel stream with SOF/EOL markers.
// Revision : 1.0
// ============================================================================
module axi_frame_reader #(
    parameter int FRAME_WIDTH  = 1920,
    parameter int FRAME_HEIGHT = 1080,
    parameter int BURST_LEN    = 16,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] frame_base_i,
    input  logic        frame_start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [23:0] pix_data_o,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic        pix_sof_o,
    output logic        pix_eol_o
);

    localparam int TOTAL = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int RW    = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int XW    = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int YW    = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

    localparam logic [31:0]   C_ALIGN_MASK = ~(32'(BURST_LEN * 4) - 32'd1);
    localparam logic [31:0]   C_TOTAL      = 32'(TOTAL);
    localparam logic [31:0]   C_BURST      = 32'(BURST_LEN);
    localparam logic [AW:0]   C_DEPTH      = (AW+1)'(FIFO_DEPTH);
    localparam logic [XW-1:0] C_X_LAST     = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] C_Y_LAST     = YW'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_araddr;
    logic [7:0]      r_arlen;
    logic [7:0]      r_beat;
    logic [RW-1:0]   r_remaining;
    logic            r_error;
    logic            r_done;
    logic [23:0]     r_fifo [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;

    logic            w_done_set;
    logic [AW:0]     w_free;
    logic            w_arvalid, w_ar_hs, w_rready, w_r_hs, w_last_beat;
    logic            w_pix_valid, w_pix_hs;
    logic [31:0]     w_rem32, w_beats32;
    logic            w_unused_ok;

    // Beats of the next burst for a given number of pixels still to fetch.
    function automatic logic [7:0] f_len(input logic [31:0] pixels);
        logic [31:0] beats;
        beats = (pixels >= C_BURST) ? C_BURST : pixels;
        return 8'(beats - 32'd1);
    endfunction

    assign w_free      = C_DEPTH - r_count;
    assign w_arvalid   = (r_state == S_ADDR) && (32'(w_free) >= C_BURST);
    assign w_ar_hs     = w_arvalid && m_axi_arready;
    assign w_rready    = (r_state == S_DATA);
    assign w_r_hs      = w_rready && m_axi_rvalid;
    assign w_last_beat = (r_beat == r_arlen);
    assign w_pix_valid = (r_count != '0);
    assign w_pix_hs    = w_pix_valid && pix_ready_i;
    assign w_rem32     = 32'(r_remaining);
    assign w_beats32   = 32'(r_arlen) + 32'd1;
    assign w_unused_ok = &{1'b0, m_axi_rdata[31:24]};

    always_comb begin
        w_state_nxt = r_state;
        w_done_set  = 1'b0;
        case (r_state)
            S_IDLE:  if (frame_start_i) w_state_nxt = S_ADDR;
            S_ADDR:  if (w_ar_hs) w_state_nxt = S_DATA;
            S_DATA: begin
                if (w_r_hs && w_last_beat)
                    w_state_nxt = (r_remaining != '0) ? S_ADDR : S_DRAIN;
            end
            S_DRAIN: begin
                if (r_count == '0) begin
                    w_state_nxt = S_IDLE;
                    w_done_set  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_beat      <= '0;
            r_remaining <= '0;
            r_error     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (r_state == S_IDLE && frame_start_i) begin
                r_araddr    <= frame_base_i & C_ALIGN_MASK;
                r_arlen     <= f_len(C_TOTAL);
                r_remaining <= RW'(TOTAL);
                r_error     <= 1'b0;
            end
            if (w_ar_hs) begin
                r_remaining <= RW'(w_rem32 - w_beats32);
                r_araddr    <= r_araddr + (w_beats32 << 2);
                r_beat      <= '0;
            end
            // Burst length comes from our own beat count; RLAST is only checked.
            if (w_r_hs) begin
                r_beat <= r_beat + 8'd1;
                if ((m_axi_rresp != 2'b00) || (m_axi_rlast != w_last_beat))
                    r_error <= 1'b1;
                if (w_last_beat && r_remaining != '0)
                    r_arlen <= f_len(w_rem32);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_r_hs) r_fifo[r_wr_ptr] <= m_axi_rdata[23:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            if (w_r_hs) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pix_hs) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                if (r_x == C_X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == C_Y_LAST) ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
            r_count <= r_count + (AW+1)'(w_r_hs) - (AW+1)'(w_pix_hs);
        end
    end

    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = r_done;
    assign error_o       = r_error;
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'h2;
    assign m_axi_arburst = 2'h1;
    assign m_axi_arvalid = w_arvalid;
    assign m_axi_rready  = w_rready;
    assign pix_data_o    = r_fifo[r_rd_ptr];
    assign pix_valid_o   = w_pix_valid;
    assign pix_sof_o     = w_pix_valid && (r_x == '0) && (r_y == '0);
    assign pix_eol_o     = w_pix_valid && (r_x == C_X_LAST);

endmodule
`default_nettype wire

// File: tb/tb_axi_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_frame_reader
// Desc     : Directed bench for axi_frame_reader: three DUT geometries share one
//            AXI slave model and pixel monitor, selected by sel.
// Revision : 1.0
// ============================================================================
module tb_axi_frame_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] frame_base = '0;
    logic        arready, rvalid, rlast, pix_ready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    logic        busy [3], done [3], error [3], arvalid [3], rready [3];
    logic        pix_valid [3], sof [3], eol [3];
    logic [31:0] araddr [3];
    logic [7:0]  arlen [3];
    logic [2:0]  arsize [3];
    logic [1:0]  arburst [3];
    logic [23:0] pix_data [3];

    logic start0, start1, start2;
    assign start0 = start && (sel == 2'd0);
    assign start1 = start && (sel == 2'd1);
    assign start2 = start && (sel == 2'd2);

    axi_frame_reader #(.FRAME_WIDTH(4), .FRAME_HEIGHT(2), .BURST_LEN(4), .FIFO_DEPTH(8)) u_a (
        .clk_i(clk), .rst_i(rst), .frame_base_i(frame_base), .frame_start_i(start0),
        .busy_o(busy[0]), .done_o(done[0]), .error_o(error[0]),
        .m_axi_araddr(araddr[0]), .m_axi_arlen(arlen[0]), .m_axi_arsize(arsize[0]),
        .m_axi_arburst(arburst[0]), .m_axi_arvalid(arvalid[0]), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready[0]),
        .pix_data_o(pix_data[0]), .pix_valid_o(pix_valid[0]), .pix_ready_i(pix_ready),
        .pix_sof_o(sof[0]), .pix_eol_o(eol[0]));

    axi_frame_reader #(.FRAME_WIDTH(5), .FRAME_HEIGHT(1), .BURST_LEN(4), .FIFO_DEPTH(8)) u_b (
        .clk_i(clk), .rst_i(rst), .frame_base_i(frame_base), .frame_start_i(start1),
        .busy_o(busy[1]), .done_o(done[1]), .error_o(error[1]),
        .m_axi_araddr(araddr[1]), .m_axi_arlen(arlen[1]), .m_axi_arsize(arsize[1]),
        .m_axi_arburst(arburst[1]), .m_axi_arvalid(arvalid[1]), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready[1]),
        .pix_data_o(pix_data[1]), .pix_valid_o(pix_valid[1]), .pix_ready_i(pix_ready),
        .pix_sof_o(sof[1]), .pix_eol_o(eol[1]));

    axi_frame_reader #(.FRAME_WIDTH(4), .FRAME_HEIGHT(4), .BURST_LEN(4), .FIFO_DEPTH(8)) u_c (
        .clk_i(clk), .rst_i(rst), .frame_base_i(frame_base), .frame_start_i(start2),
        .busy_o(busy[2]), .done_o(done[2]), .error_o(error[2]),
        .m_axi_araddr(araddr[2]), .m_axi_arlen(arlen[2]), .m_axi_arsize(arsize[2]),
        .m_axi_arburst(arburst[2]), .m_axi_arvalid(arvalid[2]), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready[2]),
        .pix_data_o(pix_data[2]), .pix_valid_o(pix_valid[2]), .pix_ready_i(pix_ready),
        .pix_sof_o(sof[2]), .pix_eol_o(eol[2]));

    logic        dut_busy, dut_done, dut_error, dut_arvalid, dut_rready;
    logic        dut_pv, dut_sof, dut_eol;
    logic [31:0] dut_araddr;
    logic [7:0]  dut_arlen;
    logic [2:0]  dut_arsize;
    logic [1:0]  dut_arburst;
    logic [23:0] dut_data;
    assign dut_busy    = busy[sel];
    assign dut_done    = done[sel];
    assign dut_error   = error[sel];
    assign dut_arvalid = arvalid[sel];
    assign dut_rready  = rready[sel];
    assign dut_pv      = pix_valid[sel];
    assign dut_sof     = sof[sel];
    assign dut_eol     = eol[sel];
    assign dut_araddr  = araddr[sel];
    assign dut_arlen   = arlen[sel];
    assign dut_arsize  = arsize[sel];
    assign dut_arburst = arburst[sel];
    assign dut_data    = pix_data[sel];

    // Slave knobs and monitor logs
    logic [31:0] mem_base = '0;
    int          err_pix = -1;
    bit          early_rlast = 1'b0;
    bit          toggle = 1'b0;

    int          ar_cnt, wr_cnt, rd_cnt, pix_cnt, done_cnt, occ_viol, stall_viol;
    int          first_wr_cyc, first_pv_cyc, err_beat_cyc, err_rise_cyc;
    logic [31:0] ar_addr_log [16];
    logic [7:0]  ar_len_log [16];
    logic [23:0] pix_log [32];
    logic        sof_log [32], eol_log [32];

    int checks = 0;
    int failures = 0;

    task automatic clear_mon();
        ar_cnt = 0; wr_cnt = 0; rd_cnt = 0; pix_cnt = 0; done_cnt = 0;
        occ_viol = 0; stall_viol = 0;
        first_wr_cyc = -1; first_pv_cyc = -1; err_beat_cyc = -1; err_rise_cyc = -1;
    endtask

    // AXI slave model plus pixel/handshake monitor. Samples at negedge, drives #1 after posedge.
    initial begin : bus
        bit          ar_hs, r_hs, p_hs, rst_seen, sl_active, prev_stall;
        logic [31:0] sl_addr;
        logic [25:0] held;
        int          sl_len, sl_beat, sl_burst, idx;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = '0; pix_ready = 1'b1;
        sl_active = 0; prev_stall = 0; held = '0; sl_addr = '0;
        sl_len = 0; sl_beat = 0; sl_burst = 0; idx = 0;
        clear_mon();
        forever begin
            @(negedge clk);
            ar_hs    = dut_arvalid && arready;
            r_hs     = rvalid && dut_rready;
            p_hs     = dut_pv && pix_ready;
            rst_seen = rst;
            if (!rst) begin
                if (dut_arvalid && (wr_cnt - rd_cnt) > 4) occ_viol++;
                if (prev_stall && dut_pv && ({dut_sof, dut_eol, dut_data} !== held)) stall_viol++;
                prev_stall = dut_pv && !pix_ready;
                held = {dut_sof, dut_eol, dut_data};
                if (ar_hs && ar_cnt < 16) begin
                    ar_addr_log[ar_cnt] = dut_araddr;
                    ar_len_log[ar_cnt]  = dut_arlen;
                    ar_cnt++;
                end
                if (r_hs) begin
                    wr_cnt++;
                    if (first_wr_cyc < 0) first_wr_cyc = cyc;
                    if (rresp != 2'b00 && err_beat_cyc < 0) err_beat_cyc = cyc;
                end
                if (dut_pv && first_pv_cyc < 0) first_pv_cyc = cyc;
                if (dut_error && err_rise_cyc < 0) err_rise_cyc = cyc;
                if (p_hs) begin
                    if (pix_cnt < 32) begin
                        pix_log[pix_cnt] = dut_data;
                        sof_log[pix_cnt] = dut_sof;
                        eol_log[pix_cnt] = dut_eol;
                    end
                    pix_cnt++;
                    rd_cnt++;
                end
                if (dut_done) done_cnt++;
            end else begin
                prev_stall = 0;
            end
            @(posedge clk); #1;
            if (rst_seen) begin
                sl_active = 0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = '0;
            end else begin
                if (ar_hs) begin
                    sl_active = 1;
                    sl_addr   = ar_addr_log[ar_cnt-1];
                    sl_len    = int'(ar_len_log[ar_cnt-1]);
                    sl_burst  = ar_cnt - 1;
                    sl_beat   = 0;
                end else if (r_hs) begin
                    sl_beat++;
                    if (sl_beat > sl_len) sl_active = 0;
                end
                arready = !sl_active;
                rvalid  = sl_active;
                if (sl_active) begin
                    idx   = int'((sl_addr - mem_base) >> 2) + sl_beat;
                    rdata = 32'h00AABB00 + 32'(idx);
                    rresp = (idx == err_pix) ? 2'b10 : 2'b00;
                    rlast = (early_rlast && sl_burst == 0) ? (sl_beat == 1) : (sl_beat == sl_len);
                end else begin
                    rdata = '0; rresp = '0; rlast = 1'b0;
                end
                pix_ready = toggle ? !pix_ready : 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick(1);
            n++;
        end
        chki({tag, "_done_in_time"}, (done_cnt != 0) ? 1 : 0, 1);
        tick(3);
    endtask

    task automatic check_pixels(input string tag, input int n, input int w);
        logic [25:0] exp;
        chki({tag, "_pix_count"}, pix_cnt, n);
        for (int k = 0; k < n && k < 32; k++) begin
            exp = {(k == 0), ((k % w) == w - 1), 24'hAABB00 + 24'(k)};
            chk($sformatf("%s_pix%0d", tag, k), {38'd0, sof_log[k], eol_log[k], pix_log[k]},
                {38'd0, exp});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flags"}, {56'd0, dut_arvalid, dut_rready, dut_busy, dut_done,
                              dut_error, dut_pv, dut_sof, dut_eol}, 64'd0);
        chk({tag, "_araddr"}, {32'd0, dut_araddr}, 64'd0);
        chk({tag, "_arlen"}, {56'd0, dut_arlen}, 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        sel = 2'd0;
        check_reset_outputs("reset");
        tick(2);

        // Test 1: 4x2 frame, two full bursts
        clear_mon();
        mem_base = 32'h1000_0040; frame_base = 32'h1000_0040;
        pulse_start();
        chk("t1_arvalid_next_cycle", {63'd0, dut_arvalid}, 64'd1);
        chk("t1_busy", {63'd0, dut_busy}, 64'd1);
        chk("t1_araddr0", {32'd0, dut_araddr}, 64'h1000_0040);
        chk("t1_arlen0", {56'd0, dut_arlen}, 64'd3);
        chk("t1_arsize_arburst", {59'd0, dut_arsize, dut_arburst}, {59'd0, 3'h2, 2'h1});
        wait_done("t1", 200);
        chki("t1_ar_count", ar_cnt, 2);
        chk("t1_ar1_addr", {32'd0, ar_addr_log[1]}, 64'h1000_0050);
        chk("t1_ar1_len", {56'd0, ar_len_log[1]}, 64'd3);
        check_pixels("t1", 8, 4);
        chki("t1_done_once", done_cnt, 1);
        chk("t1_idle_no_error", {62'd0, dut_busy, dut_error}, 64'd0);
        chki("t1_beat_to_pixel_latency", first_pv_cyc - first_wr_cyc, 1);

        // Test 2: 5x1 frame, short trailing burst
        sel = 2'd1;
        clear_mon();
        mem_base = 32'h2000_0000; frame_base = 32'h2000_0000;
        pulse_start();
        wait_done("t2", 200);
        chki("t2_ar_count", ar_cnt, 2);
        chk("t2_ar0_len", {56'd0, ar_len_log[0]}, 64'd3);
        chk("t2_ar1_addr", {32'd0, ar_addr_log[1]}, 64'h2000_0010);
        chk("t2_ar1_len", {56'd0, ar_len_log[1]}, 64'd0);
        check_pixels("t2", 5, 5);
        chki("t2_done_once", done_cnt, 1);

        // Test 3: 4x4 frame, FIFO_DEPTH 8, downstream ready toggling
        sel = 2'd2;
        clear_mon();
        toggle = 1'b1;
        mem_base = 32'h1000_0040; frame_base = 32'h1000_0040;
        pulse_start();
        wait_done("t3", 400);
        toggle = 1'b0;
        tick(2);
        chki("t3_ar_count", ar_cnt, 4);
        chk("t3_ar3_addr", {32'd0, ar_addr_log[3]}, 64'h1000_0070);
        chki("t3_ar_while_fifo_full", occ_viol, 0);
        chki("t3_data_held_in_stall", stall_viol, 0);
        check_pixels("t3", 16, 4);

        // Test 4: RRESP error on pixel 2
        sel = 2'd0;
        clear_mon();
        err_pix = 2;
        mem_base = 32'h1000_0040; frame_base = 32'h1000_0040;
        pulse_start();
        wait_done("t4", 200);
        err_pix = -1;
        chk("t4_error_sticky", {63'd0, dut_error}, 64'd1);
        chki("t4_error_rise_latency", err_rise_cyc - err_beat_cyc, 1);
        check_pixels("t4", 8, 4);
        chki("t4_done_once", done_cnt, 1);
        clear_mon();
        pulse_start();
        chk("t4_start_clears_error", {63'd0, dut_error}, 64'd0);
        wait_done("t4b", 200);
        chk("t4b_no_error", {63'd0, dut_error}, 64'd0);

        // Test 5: RLAST on beat 1 of the first burst
        clear_mon();
        early_rlast = 1'b1;
        pulse_start();
        wait_done("t5", 200);
        early_rlast = 1'b0;
        chk("t5_error", {63'd0, dut_error}, 64'd1);
        chki("t5_ar_count", ar_cnt, 2);
        chk("t5_ar1_addr", {32'd0, ar_addr_log[1]}, 64'h1000_0050);
        check_pixels("t5", 8, 4);

        // Test 6a: start pulse while busy is ignored
        clear_mon();
        pulse_start();
        tick(4);
        pulse_start();
        wait_done("t6a", 200);
        chki("t6a_ar_count", ar_cnt, 2);
        chki("t6a_done_once", done_cnt, 1);
        chk("t6a_idle", {63'd0, dut_busy}, 64'd1 - 64'd1);

        // Test 6b: reset mid-DATA, then fresh frame from an unaligned base
        clear_mon();
        pulse_start();
        n = 0;
        while (wr_cnt < 2 && n < 50) begin
            tick(1);
            n++;
        end
        chki("t6b_reached_data", (wr_cnt >= 2) ? 1 : 0, 1);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("t6b_after_reset");
        rst = 1'b0;
        tick(2);
        chki("t6b_no_done_after_abort", done_cnt, 0);
        clear_mon();
        frame_base = 32'h1000_0047;
        pulse_start();
        chk("t6b_aligned_araddr", {32'd0, dut_araddr}, 64'h1000_0040);
        wait_done("t6b", 200);
        check_pixels("t6b", 8, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_frame_reader.md
Name: axi_frame_reader

Overview:
- AXI4 read master that fetches a stored frame from memory and emits it as a pixel stream.
- Frame layout in memory: top-down, one 32-bit word per pixel, {8'h00, RGB[23:0]}, rows contiguous.
- Reads bursts into an internal FIFO and presents pixels on a valid/ready interface with start-of-frame and end-of-line markers for the downstream video timing/output stage.

Parameters:
- FRAME_WIDTH, 1920, pixels per line.
- FRAME_HEIGHT, 1080, lines per frame.
- BURST_LEN, 16, beats per AR burst (power of 2, 1..256).
- FIFO_DEPTH, 64, pixel FIFO entries (power of 2, >= 2*BURST_LEN).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- frame_base_i  in  32  frame byte base address; low log2(BURST_LEN*4) bits treated as 0.
- frame_start_i  in  1  one-cycle pulse; starts a frame read when idle.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse after the last pixel is accepted downstream.
- error_o  out  1  sticky; set on RRESP!=0 or RLAST mismatch.
- m_axi_araddr  out  32  burst address.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  constant 3'h2.
- m_axi_arburst  out  2  constant 2'h1 (INCR).
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rlast  in  1  last beat.
- m_axi_rvalid  in  1  data valid.
- m_axi_rready  out  1  data ready.
- pix_data_o  out  24  RGB pixel, equal to rdata[23:0].
- pix_valid_o  out  1  pixel valid.
- pix_ready_i  in  1  downstream ready.
- pix_sof_o  out  1  high with pixel (0,0).
- pix_eol_o  out  1  high with pixel x==FRAME_WIDTH-1.

Behaviour:
- Reset values: arvalid=0, rready=0, araddr=0, arlen=0, busy=0, done=0, error=0, pix_valid=0, sof=0, eol=0. The FIFO, the x/y counters and the remaining-pixel counter are all cleared.
- Reset mid-frame aborts immediately. No done_o is produced. Issuer must reset the interconnect together with this block.
- FSM:
  - IDLE: frame_start_i latches the aligned base and sets remaining=W*H. Sets busy_o and clears error_o. Next state ADDR.
  - ADDR: arvalid asserts only when FIFO free entries >= BURST_LEN.
    - arlen = min(BURST_LEN, remaining)-1.
    - araddr = base + 4*issued_pixels.
    - araddr and arlen are held stable until arready.
    - On handshake: remaining -= beats; next state DATA.
  - DATA: rready=1. Each rvalid&rready writes rdata[23:0] into the FIFO and counts beats.
    - Burst ends on the internal beat count, not on rlast.
    - rlast must be asserted exactly on the final beat; rlast early or missing on the final beat sets error_o.
    - On the final beat: remaining>0 -> ADDR; remaining==0 -> DRAIN.
  - DRAIN: waits until the FIFO is empty and the last pixel handshake has completed. Then done_o pulses for 1 cycle, busy_o drops, next state IDLE.
- Only one burst is outstanding at a time; FIFO overflow is impossible by the free-space check.
- frame_start_i is ignored while busy_o=1.
- RRESP!=0: data is still forwarded, error_o is set. error_o stays set until the next accepted frame_start_i.
- Latency:
  - frame_start_i at cycle N -> arvalid at N+1 (FIFO empty).
  - R beat written at cycle M -> pix_valid_o at M+1.
- Pixel output:
  - pix_valid_o = FIFO not empty.
  - Data/sof/eol are stable while pix_valid_o & ~pix_ready_i.
  - x/y advance on pix_valid_o & pix_ready_i.
  - x wraps at FRAME_WIDTH-1 to 0 and y increments. y wraps to 0 after the last line.
- Simultaneous FIFO write and read in the same cycle: count unchanged, both succeed.
- Address arithmetic is 32-bit and wraps modulo 2^32. The 4 KB boundary is never crossed because bursts are aligned.

Test Plan:
1. W=4, H=2, BURST_LEN=4, base=0x1000_0040, memory word i = 0x00AABB00+i, pix_ready_i=1.
   - AR at 0x1000_0040 len=3, then AR at 0x1000_0050 len=3.
   - 8 pixels 0xAABB00..0xAABB07.
   - sof only on pixel 0; eol on pixels 3 and 7.
   - done_o pulses once.
2. W=5, H=1, BURST_LEN=4: second burst arlen=0 at base+0x10; 5 pixels; eol on the 5th pixel.
3. Downstream backpressure, pix_ready_i toggling 1/0 per cycle, FIFO_DEPTH=8, BURST_LEN=4:
   - The next AR is withheld while free<4.
   - No pixel is lost or duplicated; data is held while stalled.
4. RRESP=2'b10 on beat 2 of the first burst:
   - error_o rises the cycle after that beat; all pixels are still delivered; done_o still pulses.
   - A new frame_start_i clears error_o.
5. rlast asserted on beat 1 of a 4-beat burst: error_o set; the burst still completes after 4 beats.
6. frame_start_i pulsed while busy: no extra AR is issued. rst_i asserted mid-DATA: next cycle all outputs are at reset values; a fresh start reads from pixel 0 with sof.
